// File: rtl/sdram_wb_arbiter_if.sv
// Bus bundle between the Wishbone masters, the arbiter and the SDRAM controller.
// master: drives strobes and controller responses; slave: the arbiter side.
interface sdram_wb_arbiter_if #(
    parameter int NPORT = 2,
    parameter int AW    = 21,
    parameter int DW    = 16,
    parameter int SELW  = DW / 8
);
    logic [NPORT-1:0]      wb_stb;
    logic [NPORT-1:0]      wb_we;
    logic [NPORT*SELW-1:0] wb_sel;
    logic [NPORT*AW-1:0]   wb_adr;
    logic [NPORT*DW-1:0]   wb_dat_i;
    logic [DW-1:0]         wb_dat_o;
    logic [NPORT-1:0]      wb_ack;
    logic [NPORT-1:0]      grant;
    logic                  sdr_rst_n;
    logic                  sdr_init_done;
    logic                  sdr_wr_req;
    logic                  sdr_rd_req;
    logic                  sdr_wr_ack;
    logic                  sdr_rd_ack;
    logic [AW-1:0]         sdr_adr;
    logic [DW-1:0]         sdr_wdat;
    logic [DW-1:0]         sdr_rdat;
    logic [SELW-1:0]       sdr_be;
    logic [SELW-1:0]       sdr_dm;

    modport master (
        output wb_stb, wb_we, wb_sel, wb_adr, wb_dat_i,
        output sdr_init_done, sdr_wr_ack, sdr_rd_ack, sdr_rdat,
        input  wb_dat_o, wb_ack, grant, sdr_rst_n,
        input  sdr_wr_req, sdr_rd_req, sdr_adr, sdr_wdat,
        input  sdr_be, sdr_dm
    );

    modport slave (
        input  wb_stb, wb_we, wb_sel, wb_adr, wb_dat_i,
        input  sdr_init_done, sdr_wr_ack, sdr_rd_ack, sdr_rdat,
        output wb_dat_o, wb_ack, grant, sdr_rst_n,
        output sdr_wr_req, sdr_rd_req, sdr_adr, sdr_wdat,
        output sdr_be, sdr_dm
    );
endinterface

// File: rtl/sdram_wb_arbiter.sv
// Round-robin Wishbone-to-SDRAM-controller bridge with reset-delay sequencer.
// Ports: clk_p, rst_n (async), sys_reset (soft, synced), bus (slave modport).
module sdram_wb_arbiter #(
    parameter int NPORT    = 2,
    parameter int AW       = 21,
    parameter int DW       = 16,
    parameter int SELW     = DW / 8,
    parameter int INIT_DLY = 3
) (
    input  logic              clk_p,
    input  logic              rst_n,
    input  logic              sys_reset,
    sdram_wb_arbiter_if.slave bus
);
    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int CW = $clog2(INIT_DLY + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      sync_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rst_out_q, rst_out_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [PW-1:0]   g_q, g_d;
    logic [NPORT-1:0] grant_q, grant_d;
    logic [NPORT-1:0] ack_q, ack_d;
    logic            wr_req_q, wr_req_d;
    logic            rd_req_q, rd_req_d;
    logic            we_q, we_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   wdat_q, wdat_d;
    logic [SELW-1:0] be_q, be_d;
    logic [SELW-1:0] dm_q, dm_d;
    logic [DW-1:0]   dat_o_q, dat_o_d;

    logic            srst;
    logic            arb_en;
    logic            pick_ok;
    logic [PW-1:0]   pick;
    logic [PW-1:0]   idx;
    logic            p_we;
    logic [AW-1:0]   p_adr;
    logic [DW-1:0]   p_dat;
    logic [SELW-1:0] p_sel;
    logic            hit;

    // Soft reset is asynchronous to clk_p; two flops before use.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], sys_reset};
    end

    assign srst   = sync_q[1];
    assign arb_en = rst_out_q & bus.sdr_init_done;

    // First requester at or after the round-robin pointer.
    always_comb begin
        pick_ok = 1'b0;
        pick    = '0;
        idx     = '0;
        for (int i = 0; i < NPORT; i++) begin
            idx = PW'((int'(rr_q) + i) % NPORT);
            if (!pick_ok && bus.wb_stb[idx]) begin
                pick_ok = 1'b1;
                pick    = idx;
            end
        end
    end

    always_comb begin
        p_we  = 1'b0;
        p_adr = '0;
        p_dat = '0;
        p_sel = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (PW'(p) == pick) begin
                p_we  = bus.wb_we[p];
                p_adr = bus.wb_adr[p*AW +: AW];
                p_dat = bus.wb_dat_i[p*DW +: DW];
                p_sel = bus.wb_sel[p*SELW +: SELW];
            end
        end
    end

    // Only the ack matching the outstanding request direction counts.
    assign hit = (wr_req_q & bus.sdr_wr_ack) | (rd_req_q & bus.sdr_rd_ack);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rst_out_d = rst_out_q;
        rr_d      = rr_q;
        g_d       = g_q;
        grant_d   = grant_q;
        ack_d     = ack_q;
        wr_req_d  = wr_req_q;
        rd_req_d  = rd_req_q;
        we_d      = we_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        be_d      = be_q;
        dm_d      = dm_q;
        dat_o_d   = dat_o_q;

        if (!rst_out_q) begin
            if (cnt_q == CW'(INIT_DLY - 1)) rst_out_d = 1'b1;
            else                            cnt_d     = cnt_q + CW'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (arb_en && pick_ok) begin
                    g_d    = pick;
                    we_d   = p_we;
                    adr_d  = p_adr;
                    wdat_d = p_dat;
                    be_d   = p_we ? p_sel : '1;
                    dm_d   = p_we ? ~p_sel : '0;
                    for (int p = 0; p < NPORT; p++)
                        grant_d[p] = (PW'(p) == pick);
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                wr_req_d = we_q;
                rd_req_d = ~we_q;
                if (hit) begin
                    wr_req_d = 1'b0;
                    rd_req_d = 1'b0;
                    // An aborted strobe still completes but is not acked.
                    ack_d[g_q] = bus.wb_stb[g_q];
                    if (!we_q) dat_o_d = bus.sdr_rdat;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!bus.wb_stb[g_q]) begin
                    ack_d   = '0;
                    grant_d = '0;
                    rr_d    = (g_q == PW'(NPORT - 1)) ? '0 : g_q + PW'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (srst) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            rst_out_d = 1'b0;
            rr_d      = '0;
            g_d       = '0;
            grant_d   = '0;
            ack_d     = '0;
            wr_req_d  = 1'b0;
            rd_req_d  = 1'b0;
            we_d      = 1'b0;
            adr_d     = '0;
            wdat_d    = '0;
            be_d      = '1;
            dm_d      = '0;
            dat_o_d   = '0;
        end
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rst_out_q <= 1'b0;
            rr_q      <= '0;
            g_q       <= '0;
            grant_q   <= '0;
            ack_q     <= '0;
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            wdat_q    <= '0;
            be_q      <= '1;
            dm_q      <= '0;
            dat_o_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rst_out_q <= rst_out_d;
            rr_q      <= rr_d;
            g_q       <= g_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            wr_req_q  <= wr_req_d;
            rd_req_q  <= rd_req_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            be_q      <= be_d;
            dm_q      <= dm_d;
            dat_o_q   <= dat_o_d;
        end
    end

    assign bus.wb_dat_o   = dat_o_q;
    assign bus.wb_ack     = ack_q;
    assign bus.grant      = grant_q;
    assign bus.sdr_rst_n  = rst_out_q;
    assign bus.sdr_wr_req = wr_req_q;
    assign bus.sdr_rd_req = rd_req_q;
    assign bus.sdr_adr    = adr_q;
    assign bus.sdr_wdat   = wdat_q;
    assign bus.sdr_be     = be_q;
    assign bus.sdr_dm     = dm_q;
endmodule
